// File: rtl/add_sub_pkg.sv
// Shared types, opcodes and sign-magnitude conversion helpers for add_sub_unit.
package add_sub_pkg;

   typedef logic [2:0] sm3_t;
   typedef logic [3:0] sm4_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Negative zero (100) decodes to 0 naturally, since 0 - 0 = 0.
   function automatic logic signed [3:0] sm_to_signed(input sm3_t v);
      logic signed [3:0] mag;
      mag = signed'({2'b00, v[1:0]});
      return v[2] ? (4'sd0 - mag) : mag;
   endfunction

   function automatic sm4_t signed_to_sm(input logic signed [3:0] r);
      logic neg;
      logic signed [3:0] abs_r;
      neg   = (r < 4'sd0);
      abs_r = neg ? (4'sd0 - r) : r;
      return {neg, 3'(abs_r)};
   endfunction

endpackage

// File: rtl/add_sub_unit_if.sv
// Operand/result bundle between the ALU datapath and add_sub_unit.
interface add_sub_unit_if;
   import add_sub_pkg::*;

   sm3_t A;
   sm3_t B;
   logic ctrl;
   logic in_valid;
   sm4_t C;
   logic sign;
   logic zero;
   logic out_valid;

   modport master (output A, B, ctrl, in_valid,
                   input  C, sign, zero, out_valid);
   modport slave  (input  A, B, ctrl, in_valid,
                   output C, sign, zero, out_valid);
endinterface

// File: rtl/sm_addsub_core.sv
// Combinational sign-magnitude add/subtract: decode, signed arithmetic, encode, flags.
module sm_addsub_core
   import add_sub_pkg::*;
(
   input  sm3_t a,
   input  sm3_t b,
   input  logic ctrl,
   output sm4_t c,
   output logic sign,
   output logic zero
);

   logic signed [3:0] a_val_s;
   logic signed [3:0] b_val_s;
   logic signed [3:0] r_s;
   sm4_t              c_s;

   assign a_val_s = sm_to_signed(a);
   assign b_val_s = sm_to_signed(b);
   assign r_s     = (ctrl == OP_SUB) ? (a_val_s - b_val_s) : (a_val_s + b_val_s);
   assign c_s     = signed_to_sm(r_s);

   // Flags come from the encoded result so they can never disagree with C.
   assign c    = c_s;
   assign sign = c_s[3];
   assign zero = ~|c_s[2:0];

endmodule

// File: rtl/add_sub_unit.sv
// Registered sign-magnitude adder/subtractor slice.
// Define ADD_SUB_INPUT_REG_EN to add an input register stage (latency 2).
module add_sub_unit
   import add_sub_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   add_sub_unit_if.slave bus
);

   sm3_t a_s;
   sm3_t b_s;
   logic ctrl_s;
   logic valid_s;

`ifdef ADD_SUB_INPUT_REG_EN
   sm3_t a_r;
   sm3_t b_r;
   logic ctrl_r;
   logic valid_r;

   // Input stage; operands load only when qualified so idle X never enters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= 3'b000;
         b_r     <= 3'b000;
         ctrl_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            a_r    <= bus.A;
            b_r    <= bus.B;
            ctrl_r <= bus.ctrl;
         end
      end
   end

   assign a_s     = a_r;
   assign b_s     = b_r;
   assign ctrl_s  = ctrl_r;
   assign valid_s = valid_r;
`else
   assign a_s     = bus.A;
   assign b_s     = bus.B;
   assign ctrl_s  = bus.ctrl;
   assign valid_s = bus.in_valid;
`endif

   sm4_t core_c_s;
   logic core_sign_s;
   logic core_zero_s;

   sm_addsub_core u_core (
      .a    (a_s),
      .b    (b_s),
      .ctrl (ctrl_s),
      .c    (core_c_s),
      .sign (core_sign_s),
      .zero (core_zero_s)
   );

   sm4_t c_r;
   logic sign_r;
   logic zero_r;
   logic out_valid_r;

   // Result stage: holds the last result while idle, out_valid tracks acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_r         <= 4'b0000;
         sign_r      <= 1'b0;
         zero_r      <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= valid_s;
         if (valid_s) begin
            c_r    <= core_c_s;
            sign_r <= core_sign_s;
            zero_r <= core_zero_s;
         end
      end
   end

   assign bus.C         = c_r;
   assign bus.sign      = sign_r;
   assign bus.zero      = zero_r;
   assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_add_sub_unit.sv
// Scoreboard bench for add_sub_unit: directed vectors, full sweep, valid/reset timing.
module tb_add_sub_unit;
   import add_sub_pkg::*;

`ifdef ADD_SUB_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   add_sub_unit_if bus ();

   add_sub_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [3:0] exp_q[$];
   int         edge_q[$];
   logic [3:0] last_c = 4'b0000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Independent integer model of sign-magnitude add/subtract.
   function automatic logic [3:0] model(input logic [2:0] a, input logic [2:0] b, input logic c);
      int av, bv, r;
      av = int'(a[1:0]);
      bv = int'(b[1:0]);
      if (a[2]) av = -av;
      if (b[2]) bv = -bv;
      r = c ? (av - bv) : (av + bv);
      if (r < 0) return {1'b1, 3'(-r)};
      return {1'b0, 3'(r)};
   endfunction

   task automatic op(input logic [2:0] a, input logic [2:0] b, input logic c, input logic [3:0] e);
      @(negedge clk);
      bus.A        = a;
      bus.B        = b;
      bus.ctrl     = c;
      bus.in_valid = 1'b1;
      exp_q.push_back(e);
      edge_q.push_back(cyc + LAT);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   // Monitor: pops expected results whenever the DUT presents one.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         last_c = 4'b0000;
      end else begin
         chk("inv_zero", 32'(bus.zero), 32'(~|bus.C[2:0]));
         chk("inv_sign", 32'(bus.sign), 32'(bus.C[3]));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 32'(bus.C), 32'hFFFF_FFFF);
            end else begin
               logic [3:0] e;
               int ed;
               e  = exp_q.pop_front();
               ed = edge_q.pop_front();
               chk("result_C", 32'(bus.C), 32'(e));
               chk("result_sign", 32'(bus.sign), 32'(e[3]));
               chk("result_zero", 32'(bus.zero), 32'(e[2:0] == 3'b000));
               chk("latency", 32'(cyc), 32'(ed));
            end
            last_c = bus.C;
         end else begin
            chk("hold_C", 32'(bus.C), 32'(last_c));
         end
      end
   end

   initial begin
      bus.A        = 3'b000;
      bus.B        = 3'b000;
      bus.ctrl     = 1'b0;
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_C", 32'(bus.C), 32'h0);
      chk("reset_zero", 32'(bus.zero), 32'h1);
      chk("reset_sign", 32'(bus.sign), 32'h0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      op(3'b011, 3'b111, OP_ADD, 4'b0000);
      op(3'b011, 3'b111, OP_SUB, 4'b0110);
      op(3'b111, 3'b011, OP_SUB, 4'b1110);
      op(3'b101, 3'b010, OP_ADD, 4'b0001);
      op(3'b100, 3'b000, OP_ADD, 4'b0000);
      op(3'b100, 3'b001, OP_SUB, 4'b1001);
      op(3'b110, 3'b101, OP_ADD, 4'b1011);
      idle(3);
      op(3'b001, 3'b110, OP_SUB, 4'b0011);
      idle(2);

      // Sweep all 49 decoded pairs (codes 0..3 and 5..7) in both modes, back to back.
      for (int c = 0; c < 2; c++) begin
         for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
               if (ai != 4 && bi != 4) begin
                  op(3'(ai), 3'(bi), 1'(c), model(3'(ai), 3'(bi), 1'(c)));
               end
            end
         end
      end
      op(3'b111, 3'b011, OP_SUB, 4'b1110);
      idle(1);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      chk("drain", 32'(exp_q.size()), 32'h0);

      // Async reset with an operation in flight: no edge needed, result discarded.
      @(negedge clk);
      bus.A        = 3'b011;
      bus.B        = 3'b011;
      bus.ctrl     = OP_ADD;
      bus.in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_C", 32'(bus.C), 32'h0);
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("async_rst_zero", 32'(bus.zero), 32'h1);
      @(posedge clk);
      #1;
      chk("rst_hold_C", 32'(bus.C), 32'h0);
      chk("rst_hold_out_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      idle(3);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("post_rst_C", 32'(bus.C), 32'h0);

      op(3'b010, 3'b001, OP_ADD, 4'b0011);
      idle(1);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      chk("final_drain", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
